// File: rtl/camera_scroll.sv
// Per-frame camera controller: tracks the climber with a deadband and a
// rate-limited step, committing world-to-screen offsets only at frame start.
module camera_scroll #(
    parameter int SCREEN_W = 1024,
    parameter int SCREEN_H = 768,
    parameter int WORLD_W  = 2048,
    parameter int WORLD_H  = 4096,
    parameter int ANCHOR_X = 512,
    parameter int ANCHOR_Y = 384,
    parameter int DEADBAND = 4,
    parameter int SHIFT    = 3,
    parameter int MAX_STEP = 16,
    parameter int INIT_Y   = 3328
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               vsync,
    input  logic               enable,
    input  logic               recenter,
    input  logic signed [11:0] target_x,
    input  logic signed [12:0] target_y,
    output logic signed [11:0] screenx,
    output logic signed [12:0] screeny,
    output logic               moving,
    output logic               frame_done
);

    typedef enum logic [1:0] {IDLE, LATCH, CALC, COMMIT} state_t;

    localparam logic signed [13:0] X_MAX  = 14'(WORLD_W - SCREEN_W);
    localparam logic signed [13:0] Y_MAX  = 14'(WORLD_H - SCREEN_H);
    localparam logic signed [13:0] ANC_X  = 14'(ANCHOR_X);
    localparam logic signed [13:0] ANC_Y  = 14'(ANCHOR_Y);
    localparam logic        [13:0] DB     = 14'(DEADBAND);
    localparam logic        [13:0] MAXS   = 14'(MAX_STEP);

    state_t             state_q, state_d;
    logic               vsync_q, vsync_d;
    logic               flag_q, flag_d;
    logic signed [13:0] desx_q, desx_d, desy_q, desy_d;
    logic signed [11:0] screenx_q, screenx_d;
    logic signed [12:0] screeny_q, screeny_d;
    logic               moving_q, moving_d;
    logic               frame_done_q, frame_done_d;

    logic               frame_start;
    logic signed [13:0] cur_x, cur_y, nx, ny;

    function automatic logic signed [13:0] clamp(input logic signed [13:0] v,
                                                 input logic signed [13:0] hi);
        if (v[13])
            return '0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Step is bounded by |err| (mag >= 1 only when |err| > DEADBAND), so no overshoot.
    function automatic logic signed [13:0] step_axis(input logic signed [13:0] des,
                                                     input logic signed [13:0] cur,
                                                     input logic               snap);
        logic signed [13:0] err;
        logic        [13:0] mag;
        err = des - cur;
        mag = err[13] ? $unsigned(-err) : $unsigned(err);
        if (snap)
            return des;
        if (mag <= DB)
            return cur;
        mag = mag >> SHIFT;
        if (mag == '0)
            mag = 14'd1;
        else if (mag > MAXS)
            mag = MAXS;
        return err[13] ? cur - $signed(mag) : cur + $signed(mag);
    endfunction

    assign frame_start = vsync_q & ~vsync;
    assign cur_x       = {{2{screenx_q[11]}}, screenx_q};
    assign cur_y       = {screeny_q[12], screeny_q};

    always_comb begin
        state_d      = state_q;
        vsync_d      = vsync;
        flag_d       = flag_q | recenter;
        desx_d       = desx_q;
        desy_d       = desy_q;
        screenx_d    = screenx_q;
        screeny_d    = screeny_q;
        moving_d     = moving_q;
        frame_done_d = 1'b0;
        nx           = cur_x;
        ny           = cur_y;
        unique case (state_q)
            IDLE: if (frame_start && enable) state_d = LATCH;
            LATCH: begin
                desx_d  = clamp({{2{target_x[11]}}, target_x} - ANC_X, X_MAX);
                desy_d  = clamp({target_y[12], target_y} - ANC_Y, Y_MAX);
                state_d = CALC;
            end
            CALC: begin
                nx           = step_axis(desx_q, cur_x, flag_q | recenter);
                ny           = step_axis(desy_q, cur_y, flag_q | recenter);
                screenx_d    = 12'(nx);
                screeny_d    = 13'(ny);
                moving_d     = (nx != cur_x) || (ny != cur_y);
                flag_d       = 1'b0;
                frame_done_d = 1'b1;
                state_d      = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b1;
            flag_q       <= 1'b0;
            desx_q       <= '0;
            desy_q       <= '0;
            screenx_q    <= '0;
            screeny_q    <= 13'(INIT_Y);
            moving_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            flag_q       <= flag_d;
            desx_q       <= desx_d;
            desy_q       <= desy_d;
            screenx_q    <= screenx_d;
            screeny_q    <= screeny_d;
            moving_q     <= moving_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign screenx    = screenx_q;
    assign screeny    = screeny_q;
    assign moving     = moving_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_camera_scroll.sv
// Directed bench for camera_scroll: hand-computed offsets per frame.
module tb_camera_scroll;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               vsync;
    logic               enable;
    logic               recenter;
    logic signed [11:0] target_x;
    logic signed [12:0] target_y;
    logic signed [11:0] screenx;
    logic signed [12:0] screeny;
    logic               moving;
    logic               frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int lat, pulses;

    camera_scroll dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .enable     (enable),
        .recenter   (recenter),
        .target_x   (target_x),
        .target_y   (target_y),
        .screenx    (screenx),
        .screeny    (screeny),
        .moving     (moving),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Falling vsync edge (cycle E), optional recenter on E; index 3 is E+3.
    task automatic frame(input logic rc, output int lat_o, output int pulses_o);
        lat_o    = -1;
        pulses_o = 0;
        @(posedge clock); #1 vsync = 1'b0; recenter = rc;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (frame_done) begin
                pulses_o++;
                if (lat_o < 0) lat_o = i;
            end
            @(posedge clock); #1 recenter = 1'b0;
            if (i == 3) vsync = 1'b1;
        end
    endtask

    task automatic chk_xy(input string tag, input int ex, input int ey, input int emv);
        chk({tag, ".x"}, int'(screenx), ex);
        chk({tag, ".y"}, int'(screeny), ey);
        chk({tag, ".mv"}, int'(moving), emv);
    endtask

    initial begin
        reset_n  = 1'b0;
        vsync    = 1'b1;
        enable   = 1'b0;
        recenter = 1'b0;
        target_x = 12'sd512;
        target_y = 13'sd2000;
        repeat (3) @(negedge clock);
        chk_xy("rst", 0, 3328, 0);
        chk("rst.fd", int'(frame_done), 0);
        @(posedge clock); #1 reset_n = 1'b1; enable = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Large negative error, step clipped to MAX_STEP
        frame(1'b0, lat, pulses);
        chk("s1.lat", lat, 3);
        chk("s1.pulses", pulses, 1);
        chk_xy("s1", 0, 3312, 1);

        frame(1'b1, lat, pulses);
        chk_xy("s2.snap", 0, 1616, 1);
        target_y = 13'sd2003;
        frame(1'b0, lat, pulses);
        chk_xy("s2.db", 0, 1616, 0);
        chk("s2.pulses", pulses, 1);

        // Proportional step on y, clipped step on x
        target_y = 13'sd2030; target_x = 12'sd700;
        frame(1'b0, lat, pulses);
        chk_xy("s3a", 16, 1619, 1);
        target_y = 13'sd2010;
        frame(1'b0, lat, pulses);
        chk_xy("s3b", 32, 1620, 1);

        // Clamp to world bounds
        target_y = 13'sd100; target_x = 12'sd2000;
        frame(1'b1, lat, pulses);
        chk_xy("s4.lo", 1024, 0, 1);
        target_y = 13'sd4095;
        frame(1'b1, lat, pulses);
        chk_xy("s4.hi", 1024, 3328, 1);

        // Disabled frames: no commits, recenter held until re-enabled
        enable = 1'b0;
        for (int f = 0; f < 3; f++) begin
            target_y = 13'(1000 + 300 * f);
            target_x = 12'(600 + 50 * f);
            frame(f == 0, lat, pulses);
            chk("s5.pulses", pulses, 0);
            chk_xy("s5.hold", 1024, 3328, 1);
        end
        enable   = 1'b1;
        target_y = 13'sd2000; target_x = 12'sd512;
        frame(1'b0, lat, pulses);
        chk("s5.lat", lat, 3);
        chk_xy("s5.rc", 0, 1616, 1);

        // Asynchronous reset at E+2
        @(posedge clock); #1 vsync = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1 reset_n = 1'b0;
        #1;
        chk_xy("s6.rst", 0, 3328, 0);
        chk("s6.fd", int'(frame_done), 0);
        @(posedge clock); #1 vsync = 1'b1;
        @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #1;
        frame(1'b0, lat, pulses);
        chk("s6.lat", lat, 3);
        chk("s6.pulses", pulses, 1);
        chk_xy("s6", 0, 3312, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
